// File: rtl/axi_lite_ram_slave_if.sv
// AXI-lite bus bundle between a hub port and the RAM slave.
// Five channels (aw, w, b, ar, r); clock and reset stay outside the bundle.
interface axi_lite_ram_slave_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awport;
    logic              awvalid;
    logic              awready;

    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;

    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arport;
    logic              arvalid;
    logic              arready;

    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awport, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arport, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awport, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arport, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_ram_slave.sv
// AXI-lite slave RAM with byte-strobe writes and independent read/write FSMs.
// Optional response wait states are enabled with the AXI_RAM_WAIT_EN macro.
//
// Handshake contract: a transfer happens on the rising edge where valid and
// ready are both high. aw and w are taken together only when both are valid;
// bvalid/rvalid, together with bresp/rresp/rdata, are held stable until the
// matching bready/rready edge, and read as zero whenever their valid is low.
module axi_lite_ram_slave #(
    parameter int          AXI_ADDR_WIDTH = 64,
    parameter int          AXI_DATA_WIDTH = 64,
    parameter logic [63:0] MEM_BEGIN      = 64'h8000_0000,
    parameter int          MEM_WORDS      = 4096,
    parameter int          WAIT_CYCLES    = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    axi_lite_ram_slave_if.slave  bus,
    output logic [1:0]           w_state_dbg,
    output logic [1:0]           r_state_dbg
);
    localparam int STRB  = AXI_DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(STRB);
    localparam int IDX_W = $clog2(MEM_WORDS);

    localparam logic [AXI_ADDR_WIDTH-1:0] BASE  = AXI_ADDR_WIDTH'(MEM_BEGIN);
    localparam logic [AXI_ADDR_WIDTH-1:0] SPAN  = AXI_ADDR_WIDTH'(MEM_WORDS * STRB);
    localparam logic [AXI_ADDR_WIDTH-1:0] LIMIT = BASE + SPAN;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_RESP = 2'd1,
        W_WAIT = 2'd2
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_READ = 2'd1,
        R_RESP = 2'd2,
        R_WAIT = 2'd3
    } r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic                      w_accept;
    logic                      r_accept;
    logic                      bresp_err_q;
    logic                      ar_hit_q;
    logic [IDX_W-1:0]          ar_idx_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

    // Address decode: offset from the window base, low byte-lane bits dropped.
    logic [AXI_ADDR_WIDTH-1:0] aw_off;
    logic [AXI_ADDR_WIDTH-1:0] ar_off;
    logic [IDX_W-1:0]          aw_idx;
    logic [IDX_W-1:0]          ar_idx;
    logic                      aw_hit;
    logic                      ar_hit;

    assign aw_off = bus.awaddr - BASE;
    assign ar_off = bus.araddr - BASE;
    assign aw_idx = aw_off[OFF_W +: IDX_W];
    assign ar_idx = ar_off[OFF_W +: IDX_W];
    assign aw_hit = (bus.awaddr >= BASE) && (bus.awaddr < LIMIT);
    assign ar_hit = (bus.araddr >= BASE) && (bus.araddr < LIMIT);

    logic unused_bits;
    assign unused_bits = ^{bus.awport, bus.arport, aw_off, ar_off};

`ifdef AXI_RAM_WAIT_EN
    localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_cnt <= '0;
        end else if (w_accept) begin
            w_cnt <= CNT_W'(WAIT_CYCLES);
        end else if (w_state == W_WAIT && w_cnt != '0) begin
            w_cnt <= w_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (r_state == R_READ) begin
            r_cnt <= CNT_W'(WAIT_CYCLES);
        end else if (r_state == R_WAIT && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end
`else
    localparam int unused_wait_cycles = WAIT_CYCLES;
`endif

    // Write channel
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state     <= W_IDLE;
            bresp_err_q <= 1'b0;
        end else begin
            w_state <= w_next;
            if (w_accept) begin
                bresp_err_q <= !aw_hit;
            end
        end
    end

    always_comb begin
        w_next   = w_state;
        w_accept = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (bus.awvalid && bus.wvalid) begin
                    w_accept = 1'b1;
`ifdef AXI_RAM_WAIT_EN
                    w_next = (WAIT_CYCLES > 0) ? W_WAIT : W_RESP;
`else
                    w_next = W_RESP;
`endif
                end
            end
`ifdef AXI_RAM_WAIT_EN
            W_WAIT: begin
                // The counter reaches zero on the same edge that enters W_RESP.
                if (w_cnt <= CNT_W'(1)) begin
                    w_next = W_RESP;
                end
            end
`endif
            W_RESP: begin
                if (bus.bready) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign bus.awready = w_accept;
    assign bus.wready  = w_accept;
    assign bus.bvalid  = (w_state == W_RESP);
    assign bus.bresp   = (w_state == W_RESP) ? {bresp_err_q, 1'b0} : 2'b00;

    // Read channel
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= R_IDLE;
            ar_hit_q <= 1'b0;
            ar_idx_q <= '0;
        end else begin
            r_state <= r_next;
            if (r_accept) begin
                ar_hit_q <= ar_hit;
                ar_idx_q <= ar_idx;
            end
        end
    end

    always_comb begin
        r_next   = r_state;
        r_accept = 1'b0;
        case (r_state)
            R_IDLE: begin
                if (bus.arvalid) begin
                    r_accept = 1'b1;
                    r_next   = R_READ;
                end
            end
            R_READ: begin
`ifdef AXI_RAM_WAIT_EN
                r_next = (WAIT_CYCLES > 0) ? R_WAIT : R_RESP;
`else
                r_next = R_RESP;
`endif
            end
`ifdef AXI_RAM_WAIT_EN
            R_WAIT: begin
                if (r_cnt <= CNT_W'(1)) begin
                    r_next = R_RESP;
                end
            end
`endif
            R_RESP: begin
                if (bus.rready) begin
                    r_next = R_IDLE;
                end
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign bus.arready = r_accept;
    assign bus.rvalid  = (r_state == R_RESP);
    assign bus.rdata   = (r_state == R_RESP) ? rdata_q : '0;
    assign bus.rresp   = (r_state == R_RESP) ? {!ar_hit_q, 1'b0} : 2'b00;

    // RAM array: no reset so contents survive rstn; the read samples the old
    // word when a write to the same index lands on the same edge.
    always_ff @(posedge clk) begin
        if (w_accept && aw_hit) begin
            for (int k = 0; k < STRB; k++) begin
                if (bus.wstrb[k]) begin
                    mem[aw_idx][k*8 +: 8] <= bus.wdata[k*8 +: 8];
                end
            end
        end
        if (r_state == R_READ) begin
            rdata_q <= ar_hit_q ? mem[ar_idx_q] : '0;
        end
    end

    assign w_state_dbg = w_state;
    assign r_state_dbg = r_state;
endmodule
